// File: rtl/julia_pixel_sequencer_if.sv
// rtl/julia_pixel_sequencer_if.sv - engine handshake and frame-buffer write bundle for julia_pixel_sequencer
//
// Signals:
//   start        control -> sequencer   frame request
//   ready_in     engine  -> sequencer   engine ready level
//   fin_iter_in  engine  -> sequencer   final iteration count, 0..256
//   x_com/y_com  sequencer -> engine    Q16.16 pixel coordinate
//   wr_en/wr_addr/wr_data sequencer -> frame buffer
//   busy/frame_done       sequencer -> control
// Modports: master = sequencer side, slave = engine/control/frame-buffer side.

interface julia_pixel_sequencer_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic              ready_in;
    logic [8:0]        fin_iter_in;
    logic [31:0]       x_com;
    logic [31:0]       y_com;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, ready_in, fin_iter_in,
        output x_com, y_com, wr_en, wr_addr, wr_data, busy, frame_done
    );

    modport slave (
        output start, ready_in, fin_iter_in,
        input  x_com, y_com, wr_en, wr_addr, wr_data, busy, frame_done
    );
endinterface

// File: rtl/julia_pixel_sequencer.sv
// rtl/julia_pixel_sequencer.sv - raster-scan coordinate sequencer and frame-buffer writer for the julia_set engine
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  julia_pixel_sequencer_if.master (start, ready_in, fin_iter_in in;
//        x_com, y_com, wr_en, wr_addr, wr_data, busy, frame_done out)
// Optional feature macro: JULIA_SEQ_CONTINUOUS_EN - after the last pixel keep
//   running the next frame instead of returning to IDLE.

module julia_pixel_sequencer #(
    parameter int          H_RES   = 640,
    parameter int          V_RES   = 480,
    parameter int          ADDR_W  = 19,
    parameter logic [31:0] X_START = 32'hFFFE_8000,
    parameter logic [31:0] Y_START = 32'h0001_3333,
    parameter logic [31:0] STEP    = 32'h0000_0133
) (
    input  logic                      clk,
    input  logic                      rst,
    julia_pixel_sequencer_if.master   bus
);
    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready_q;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_x_com;
    logic [31:0]       r_y_com;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_frame_done;

    logic w_rise;
    logic w_accept;
    logic w_write;
    logic w_last_x;
    logic w_last_y;

    assign w_rise   = bus.ready_in & ~r_ready_q;
    assign w_last_x = (r_x == X_W'(H_RES - 1));
    assign w_last_y = (r_y == Y_W'(V_RES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FLUSH;
                end
            end
            // The first result was computed from whatever coordinate was on
            // the bus before start, so it is dropped.
            S_FLUSH: begin
                if (w_rise) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_rise) begin
                    w_write = 1'b1;
                    if (w_last_x && w_last_y) begin
`ifdef JULIA_SEQ_CONTINUOUS_EN
                        // Coordinates wrap to pixel 0 at this edge, so the
                        // engine's next computation is already valid.
                        w_state_nxt = S_RUN;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready_q    <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_x_com      <= X_START;
            r_y_com      <= Y_START;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_ready_q    <= bus.ready_in;
            r_wr_en      <= w_write;
            r_frame_done <= w_write & w_last_x & w_last_y;
            if (w_accept) begin
                r_x     <= '0;
                r_y     <= '0;
                r_addr  <= '0;
                r_x_com <= X_START;
                r_y_com <= Y_START;
            end else if (w_write) begin
                r_wr_addr <= r_addr;
                // Iteration count 256 means the point never escaped: black.
                r_wr_data <= bus.fin_iter_in[8] ? 8'h00 : bus.fin_iter_in[7:0];
                if (w_last_x) begin
                    r_x     <= '0;
                    r_x_com <= X_START;
                    if (w_last_y) begin
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_y_com <= Y_START;
                    end else begin
                        r_y     <= r_y + Y_W'(1);
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_y_com <= r_y_com - STEP;
                    end
                end else begin
                    r_x     <= r_x + X_W'(1);
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_x_com <= r_x_com + STEP;
                end
            end
        end
    end

    assign bus.x_com      = r_x_com;
    assign bus.y_com      = r_y_com;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_julia_pixel_sequencer.sv
// tb/tb_julia_pixel_sequencer.sv - self-checking bench for julia_pixel_sequencer on a 4x3 frame

module tb_julia_pixel_sequencer;
    localparam int          H   = 4;
    localparam int          V   = 3;
    localparam int          AW  = 4;
    localparam logic [31:0] XS  = 32'hFFFE_8000;
    localparam logic [31:0] YS  = 32'h0001_3333;
    localparam logic [31:0] ST  = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    julia_pixel_sequencer_if #(.ADDR_W(AW)) bus ();

    julia_pixel_sequencer #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW),
        .X_START(XS), .Y_START(YS), .STEP(ST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;
    // Reference model: 0 idle, 1 waiting to discard, 2 producing pixels.
    int m_state = 0;
    int m_idx   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_x();
        return XS + 32'(m_idx % H) * ST;
    endfunction

    function automatic logic [31:0] exp_y();
        return YS - 32'(m_idx / H) * ST;
    endfunction

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        if (m_state == 0) begin
            m_state = 1;
            m_idx   = 0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", 64'(bus.busy), 64'(m_state != 0));
        check("start_x", 64'(bus.x_com), 64'(exp_x()));
        check("start_y", 64'(bus.y_com), 64'(exp_y()));
    endtask

    task automatic rise(input logic [8:0] fin, input int hold, input int gap);
        logic exp_we;
        logic exp_fd;
        int   addr;
        exp_we = 1'b0;
        exp_fd = 1'b0;
        addr   = m_idx;
        @(negedge clk);
        bus.ready_in    = 1'b1;
        bus.fin_iter_in = fin;
        if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            exp_we = 1'b1;
            if (m_idx == H * V - 1) begin
                exp_fd = 1'b1;
                m_idx  = 0;
`ifndef JULIA_SEQ_CONTINUOUS_EN
                m_state = 0;
`endif
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
        check("wr_en", 64'(bus.wr_en), 64'(exp_we));
        check("frame_done", 64'(bus.frame_done), 64'(exp_fd));
        check("busy", 64'(bus.busy), 64'(m_state != 0));
        check("x_com", 64'(bus.x_com), 64'(exp_x()));
        check("y_com", 64'(bus.y_com), 64'(exp_y()));
        if (exp_we) begin
            check("wr_addr", 64'(bus.wr_addr), 64'(addr));
            check("wr_data", 64'(bus.wr_data), 64'(fin[8] ? 8'h00 : fin[7:0]));
        end
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            check("hold_wr_en", 64'(bus.wr_en), 64'd0);
        end
        bus.ready_in = 1'b0;
        @(negedge clk);
        check("stable_x", 64'(bus.x_com), 64'(exp_x()));
        check("stable_y", 64'(bus.y_com), 64'(exp_y()));
        check("single_wr", 64'(bus.wr_en), 64'd0);
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_pixels(input int n);
        logic [8:0] fin;
        for (int i = 0; i < n; i++) begin
            fin = 9'($urandom_range(0, 256));
            rise(fin, int'($urandom_range(1, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.ready_in    = 1'b0;
        bus.fin_iter_in = 9'd0;
        repeat (2) @(negedge clk);
        check("rst_x", 64'(bus.x_com), 64'(XS));
        check("rst_y", 64'(bus.y_com), 64'(YS));
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_data", 64'(bus.wr_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_fd", 64'(bus.frame_done), 64'd0);
        rst = 1'b0;

        // Rise while idle must not write.
        rise(9'd7, 1, 0);

        // Frame 1: pixel index as data, forced 256/255 cases, mid-frame start.
        do_start();
        rise(9'd99, 1, 0);
        for (int i = 0; i < H * V; i++) begin
            logic [8:0] fin;
            fin = 9'(i);
            if (i == 2) fin = 9'd256;
            if (i == 3) fin = 9'd255;
            if (i == 7) do_start();
            rise(fin, (i == 6) ? 2 : 1, int'($urandom_range(0, 2)));
        end
        check("after_frame_busy", 64'(bus.busy), 64'(m_state != 0));

`ifdef JULIA_SEQ_CONTINUOUS_EN
        // Second back-to-back frame without start or flush.
        run_pixels(H * V);
        check("cont_busy", 64'(bus.busy), 64'd1);
`endif

        // Reset at pixel 5 of a frame.
        do_start();
        if (m_state == 1) rise(9'd1, 1, 0);
        while (m_idx != 5) run_pixels(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_x", 64'(bus.x_com), 64'(XS));
        check("mid_rst_y", 64'(bus.y_com), 64'(YS));
        check("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("mid_rst_addr", 64'(bus.wr_addr), 64'd0);
        check("mid_rst_data", 64'(bus.wr_data), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_fd", 64'(bus.frame_done), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_state = 0;
        m_idx   = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_fd", 64'(bus.frame_done), 64'd0);
            check("post_rst_wr", 64'(bus.wr_en), 64'd0);
        end

        // Restart from address 0 with random results and timing.
        do_start();
        rise(9'd3, 1, 1);
        run_pixels(H * V);
        check("final_busy", 64'(bus.busy), 64'(m_state != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
